// File: rtl/frontend_command_definition_pkg.sv
// Shared types and address field layout for the frontend command interface.
// A command is {op_type, row, bank, col, len, tag}. The host address splits as {row, bank, col}.
package frontend_command_definition_pkg;

    localparam int COL_W   = 10;
    localparam int BANK_W  = 3;
    localparam int ROW_W   = 16;
    localparam int LEN_W   = 4;
    localparam int TAG_W   = 4;
    localparam int FIELD_W = COL_W + BANK_W + ROW_W;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2
    } issuer_state_t;

    typedef struct packed {
        op_t                op_type;
        logic [ROW_W-1:0]   row;
        logic [BANK_W-1:0]  bank;
        logic [COL_W-1:0]   col;
        logic [LEN_W-1:0]   len;
        logic [TAG_W-1:0]   tag;
    } frontend_command_t;

    // Fills only the address fields; op, len and tag are left at zero for the caller.
    function automatic frontend_command_t addr_to_fields(input logic [FIELD_W-1:0] addr);
        frontend_command_t c;
        c      = '0;
        c.col  = addr[COL_W-1:0];
        c.bank = addr[COL_W +: BANK_W];
        c.row  = addr[COL_W+BANK_W +: ROW_W];
        return c;
    endfunction

endpackage

// File: rtl/frontend_command_issuer.sv
// Transmit side of the frontend command interface: packs host requests into tagged commands
// and forwards write bursts to the scheduler after each write command's handshake.
module frontend_command_issuer
    import frontend_command_definition_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  op_t               host_req_op,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [LEN_W-1:0]  host_req_len,
    input  logic              host_wdata_valid,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_wdata_ready,
    output logic              o_cmd_valid,
    output frontend_command_t o_command,
    input  logic              i_cmd_ready,
    output logic              o_wdata_valid,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wlast,
    input  logic              i_wdata_ready,
    output logic              o_busy
);

    issuer_state_t     state;
    logic [TAG_W-1:0]  tag_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    frontend_command_t req_cmd;
    logic              in_wdata;
    logic              beat_fire;
    logic              unused_addr_bits;

    // Address bits above the row field carry no meaning for the scheduler.
    assign unused_addr_bits = ^host_req_addr[ADDR_W-1:FIELD_W];

    always_comb begin
        req_cmd         = addr_to_fields(host_req_addr[FIELD_W-1:0]);
        req_cmd.op_type = host_req_op;
        req_cmd.len     = host_req_len;
        req_cmd.tag     = tag_cnt;
    end

    // The write beat path is a straight pass-through, gated so that no beat can leak outside WDATA.
    assign in_wdata         = (state == S_WDATA);
    assign o_wdata_valid    = in_wdata & host_wdata_valid;
    assign o_wdata          = host_wdata;
    assign host_wdata_ready = in_wdata & i_wdata_ready;
    assign o_wlast          = o_wdata_valid & (beat_cnt == '0);
    assign beat_fire        = o_wdata_valid & i_wdata_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            o_command      <= '0;
            tag_cnt        <= '0;
            beat_cnt       <= '0;
            o_cmd_valid    <= 1'b0;
            host_req_ready <= 1'b1;
            o_busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_req_valid) begin
                        o_command      <= req_cmd;
                        o_cmd_valid    <= 1'b1;
                        host_req_ready <= 1'b0;
                        o_busy         <= 1'b1;
                        state          <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        tag_cnt     <= tag_cnt + 1'b1;
                        if (o_command.op_type == OP_WRITE) begin
                            beat_cnt <= o_command.len;
                            state    <= S_WDATA;
                        end else begin
                            host_req_ready <= 1'b1;
                            o_busy         <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end
                end
                S_WDATA: begin
                    if (beat_fire) begin
                        if (beat_cnt == '0) begin
                            host_req_ready <= 1'b1;
                            o_busy         <= 1'b0;
                            state          <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    o_cmd_valid    <= 1'b0;
                    host_req_ready <= 1'b1;
                    o_busy         <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frontend_command_issuer.sv
// Self-checking bench for frontend_command_issuer: directed scenarios plus randomized traffic
// checked against an arithmetic model of the command packing and the tag/beat sequencing.
module tb_frontend_command_issuer;
    import frontend_command_definition_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_req_valid = 1'b0;
    logic              host_req_ready;
    op_t               host_req_op = OP_READ;
    logic [ADDR_W-1:0] host_req_addr = '0;
    logic [LEN_W-1:0]  host_req_len = '0;
    logic              host_wdata_valid = 1'b0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_wdata_ready;
    logic              o_cmd_valid;
    frontend_command_t o_command;
    logic              i_cmd_ready = 1'b0;
    logic              o_wdata_valid;
    logic [DATA_W-1:0] o_wdata;
    logic              o_wlast;
    logic              i_wdata_ready = 1'b0;
    logic              o_busy;

    int checks = 0;
    int failures = 0;
    int exp_tag = 0;

    always #5 clk = ~clk;

    frontend_command_issuer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_addr(host_req_addr), .host_req_len(host_req_len),
        .host_wdata_valid(host_wdata_valid), .host_wdata(host_wdata), .host_wdata_ready(host_wdata_ready),
        .o_cmd_valid(o_cmd_valid), .o_command(o_command), .i_cmd_ready(i_cmd_ready),
        .o_wdata_valid(o_wdata_valid), .o_wdata(o_wdata), .o_wlast(o_wlast),
        .i_wdata_ready(i_wdata_ready), .o_busy(o_busy)
    );

    // Expected command from plain division/modulo on the address.
    function automatic frontend_command_t model_cmd(op_t op, longint unsigned addr, int len, int tag);
        frontend_command_t c;
        c.op_type = op;
        c.col     = COL_W'(addr % 1024);
        c.bank    = BANK_W'((addr / 1024) % 8);
        c.row     = ROW_W'((addr / 8192) % 65536);
        c.len     = LEN_W'(len);
        c.tag     = TAG_W'(tag % 16);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(op_t op, logic [ADDR_W-1:0] addr, int len);
        host_req_op    = op;
        host_req_addr  = addr;
        host_req_len   = LEN_W'(len);
        host_req_valid = 1'b1;
        tick();
        host_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (o_cmd_valid !== 1'b0 || o_wdata_valid !== 1'b0 || o_wlast !== 1'b0 || o_busy !== 1'b0)
            begin failures++; $display("FAIL reset_valids: got cv=%b wv=%b wl=%b busy=%b required all 0", o_cmd_valid, o_wdata_valid, o_wlast, o_busy); end
        checks++;
        if (host_req_ready !== 1'b1 || host_wdata_ready !== 1'b0)
            begin failures++; $display("FAIL reset_readies: got req_rdy=%b wd_rdy=%b required 1/0", host_req_ready, host_wdata_ready); end
        checks++;
        if (o_command !== '0)
            begin failures++; $display("FAIL reset_command: got %h required 0", o_command); end
        rst_n = 1'b1;
        exp_tag = 0;
        tick();
    endtask

    task automatic test_read();
        frontend_command_t e;
        i_cmd_ready = 1'b1;
        host_wdata_valid = 1'b1;
        i_wdata_ready = 1'b1;
        e = model_cmd(OP_READ, 64'h0000_1040, 3, exp_tag);
        send_req(OP_READ, 32'h0000_1040, 3);
        checks++;
        if (o_cmd_valid !== 1'b1 || o_command !== e)
            begin failures++; $display("FAIL read_cmd: got v=%b cmd=%h required v=1 cmd=%h", o_cmd_valid, o_command, e); end
        checks++;
        if (o_command.tag !== 4'd0 || o_command.bank !== 3'd4 || o_command.col !== 10'h040)
            begin failures++; $display("FAIL read_fields: got tag=%0d bank=%0d col=%h required 0/4/040", o_command.tag, o_command.bank, o_command.col); end
        checks++;
        if (o_wdata_valid !== 1'b0 || host_wdata_ready !== 1'b0)
            begin failures++; $display("FAIL read_no_wdata: got wv=%b wrdy=%b required 0/0", o_wdata_valid, host_wdata_ready); end
        tick();
        exp_tag++;
        checks++;
        if (o_cmd_valid !== 1'b0 || host_req_ready !== 1'b1 || o_busy !== 1'b0)
            begin failures++; $display("FAIL read_idle: got cv=%b rdy=%b busy=%b required 0/1/0", o_cmd_valid, host_req_ready, o_busy); end
        host_wdata_valid = 1'b0;
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] beats [4];
        frontend_command_t e;
        for (int k = 0; k < 4; k++) beats[k] = {$urandom, $urandom};
        i_cmd_ready = 1'b1;
        i_wdata_ready = 1'b1;
        host_wdata_valid = 1'b1;
        host_wdata = beats[0];
        e = model_cmd(OP_WRITE, 64'h0123_4567, 3, exp_tag);
        send_req(OP_WRITE, 32'h0123_4567, 3);
        checks++;
        if (o_cmd_valid !== 1'b1 || o_command !== e || o_wdata_valid !== 1'b0 || host_wdata_ready !== 1'b0)
            begin failures++; $display("FAIL write_cmd: got v=%b cmd=%h wv=%b required v=1 cmd=%h wv=0", o_cmd_valid, o_command, o_wdata_valid, e); end
        tick();
        exp_tag++;
        for (int k = 0; k < 4; k++) begin
            host_wdata = beats[k];
            #1;
            checks++;
            if (o_wdata_valid !== 1'b1 || o_wdata !== beats[k] || o_wlast !== (k == 3) || host_wdata_ready !== 1'b1)
                begin failures++; $display("FAIL write_beat%0d: got v=%b d=%h last=%b required v=1 d=%h last=%b", k, o_wdata_valid, o_wdata, o_wlast, beats[k], (k == 3)); end
            tick();
        end
        checks++;
        if (o_busy !== 1'b0 || host_req_ready !== 1'b1 || o_wdata_valid !== 1'b0)
            begin failures++; $display("FAIL write_idle: got busy=%b rdy=%b wv=%b required 0/1/0", o_busy, host_req_ready, o_wdata_valid); end
        host_wdata_valid = 1'b0;
    endtask

    task automatic test_cmd_stall();
        frontend_command_t e;
        logic [ADDR_W-1:0] a;
        a = $urandom;
        e = model_cmd(OP_READ, a, 7, exp_tag);
        i_cmd_ready = 1'b0;
        send_req(OP_READ, a, 7);
        host_req_addr = ~a;
        host_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (o_cmd_valid !== 1'b1 || o_command !== e || host_req_ready !== 1'b0)
                begin failures++; $display("FAIL stall_cycle%0d: got v=%b cmd=%h rdy=%b required v=1 cmd=%h rdy=0", c, o_cmd_valid, o_command, host_req_ready, e); end
            tick();
        end
        host_req_valid = 1'b0;
        i_cmd_ready = 1'b1;
        tick();
        exp_tag++;
        checks++;
        if (o_cmd_valid !== 1'b0 || host_req_ready !== 1'b1)
            begin failures++; $display("FAIL stall_release: got v=%b rdy=%b required 0/1", o_cmd_valid, host_req_ready); end
    endtask

    task automatic test_tag_wrap();
        frontend_command_t e;
        logic [ADDR_W-1:0] a;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_tag = 0;
        tick();
        i_cmd_ready = 1'b1;
        host_req_valid = 1'b1;
        host_req_op = OP_READ;
        for (int i = 0; i < 17; i++) begin
            a = $urandom;
            host_req_addr = a;
            host_req_len = LEN_W'(i);
            e = model_cmd(OP_READ, a, i % 16, i);
            checks++;
            if (host_req_ready !== 1'b1)
                begin failures++; $display("FAIL wrap_ready%0d: got %b required 1", i, host_req_ready); end
            tick();
            checks++;
            if (o_cmd_valid !== 1'b1 || o_command !== e)
                begin failures++; $display("FAIL wrap_cmd%0d: got v=%b cmd=%h required v=1 cmd=%h", i, o_cmd_valid, o_command, e); end
            tick();
        end
        host_req_valid = 1'b0;
        exp_tag = 17;
    endtask

    task automatic test_len0_toggle();
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        frontend_command_t e;
        int hs;
        hs = 0;
        d = {$urandom, $urandom};
        a = $urandom;
        e = model_cmd(OP_WRITE, a, 0, exp_tag);
        i_cmd_ready = 1'b1;
        host_wdata = d;
        host_wdata_valid = 1'b1;
        i_wdata_ready = 1'b1;
        send_req(OP_WRITE, a, 0);
        checks++;
        if (o_command !== e || host_wdata_ready !== 1'b0 || o_wdata_valid !== 1'b0)
            begin failures++; $display("FAIL len0_cmd: got cmd=%h wrdy=%b wv=%b required cmd=%h 0/0", o_command, host_wdata_ready, o_wdata_valid, e); end
        tick();
        exp_tag++;
        for (int c = 0; c < 30; c++) begin
            host_wdata_valid = (c == 12) ? 1'b1 : 1'($urandom_range(0, 1));
            i_wdata_ready    = (c == 12) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (o_wdata_valid === 1'b1 && i_wdata_ready === 1'b1) begin
                hs++;
                checks++;
                if (o_wlast !== 1'b1 || o_wdata !== d)
                    begin failures++; $display("FAIL len0_beat: got last=%b d=%h required last=1 d=%h", o_wlast, o_wdata, d); end
            end
            tick();
        end
        checks++;
        if (hs != 1)
            begin failures++; $display("FAIL len0_count: got %0d beats required 1", hs); end
        host_wdata_valid = 1'b0;
        i_wdata_ready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        frontend_command_t e;
        logic [ADDR_W-1:0] a;
        i_cmd_ready = 1'b1;
        i_wdata_ready = 1'b1;
        host_wdata_valid = 1'b1;
        send_req(OP_WRITE, $urandom, 3);
        tick();
        for (int k = 0; k < 2; k++) begin
            host_wdata = {$urandom, $urandom};
            tick();
        end
        host_wdata = {$urandom, $urandom};
        #1;
        checks++;
        if (o_wdata_valid !== 1'b1 || o_wlast !== 1'b0)
            begin failures++; $display("FAIL midrst_beat2: got v=%b last=%b required 1/0", o_wdata_valid, o_wlast); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_wdata_valid !== 1'b0 || host_wdata_ready !== 1'b0 || o_busy !== 1'b0 || host_req_ready !== 1'b1 ||
            o_cmd_valid !== 1'b0 || o_command !== '0)
            begin failures++; $display("FAIL midrst_async: got wv=%b wrdy=%b busy=%b rdy=%b cv=%b cmd=%h required 0/0/0/1/0/0", o_wdata_valid, host_wdata_ready, o_busy, host_req_ready, o_cmd_valid, o_command); end
        tick();
        rst_n = 1'b1;
        exp_tag = 0;
        host_wdata_valid = 1'b0;
        tick();
        a = $urandom;
        e = model_cmd(OP_READ, a, 2, 0);
        send_req(OP_READ, a, 2);
        checks++;
        if (o_cmd_valid !== 1'b1 || o_command !== e)
            begin failures++; $display("FAIL midrst_next: got v=%b cmd=%h required v=1 cmd=%h", o_cmd_valid, o_command, e); end
        tick();
        exp_tag++;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] beats [16];
        logic [ADDR_W-1:0] a;
        frontend_command_t e;
        op_t op;
        int len, cyc, idx;
        bit done;
        for (int t = 0; t < 30; t++) begin
            op  = ($urandom_range(0, 1) == 1) ? OP_WRITE : OP_READ;
            a   = $urandom;
            len = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) beats[k] = {$urandom, $urandom};
            e = model_cmd(op, a, len, exp_tag);
            checks++;
            if (host_req_ready !== 1'b1)
                begin failures++; $display("FAIL rnd%0d_req_ready: got %b required 1", t, host_req_ready); end
            send_req(op, a, len);
            done = 0;
            cyc = 0;
            while (!done && cyc < 100) begin
                i_cmd_ready      = 1'($urandom_range(0, 1));
                i_wdata_ready    = 1'($urandom_range(0, 1));
                host_wdata_valid = 1'($urandom_range(0, 1));
                host_wdata       = beats[0];
                #1;
                checks++;
                if (o_cmd_valid !== 1'b1 || o_wdata_valid !== 1'b0)
                    begin failures++; $display("FAIL rnd%0d_cmd_phase: got cv=%b wv=%b required 1/0", t, o_cmd_valid, o_wdata_valid); end
                if (i_cmd_ready) begin
                    checks++;
                    if (o_command !== e)
                        begin failures++; $display("FAIL rnd%0d_cmd: got %h required %h", t, o_command, e); end
                    done = 1;
                end
                tick();
                cyc++;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL rnd%0d_cmd_timeout: got no handshake required one within 100 cycles", t);
            end
            exp_tag++;
            i_cmd_ready = 1'b0;
            if (op == OP_WRITE) begin
                idx = 0;
                cyc = 0;
                while (idx <= len && cyc < 200) begin
                    host_wdata_valid = 1'($urandom_range(0, 1));
                    i_wdata_ready    = 1'($urandom_range(0, 1));
                    host_wdata       = beats[idx];
                    #1;
                    if (host_wdata_valid && i_wdata_ready) begin
                        checks++;
                        if (o_wdata_valid !== 1'b1 || o_wdata !== beats[idx] || o_wlast !== (idx == len))
                            begin failures++; $display("FAIL rnd%0d_beat%0d: got v=%b d=%h last=%b required v=1 d=%h last=%b", t, idx, o_wdata_valid, o_wdata, o_wlast, beats[idx], (idx == len)); end
                        idx++;
                    end
                    tick();
                    cyc++;
                end
                if (idx <= len) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd%0d_beat_timeout: got %0d beats required %0d", t, idx, len + 1);
                end
            end
            host_wdata_valid = 1'b0;
            checks++;
            if (o_busy !== 1'b0 || host_req_ready !== 1'b1)
                begin failures++; $display("FAIL rnd%0d_idle: got busy=%b rdy=%b required 0/1", t, o_busy, host_req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_cmd_stall();
        test_tag_wrap();
        test_len0_toggle();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
